// File: rtl/riscv_trap_pkg.sv
// Shared trap definitions: CSR addresses, cause codes, FSM states.
// Vectored mode is built only when IRQ_VECTORED_EN is defined.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

package riscv_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HANDLER
  } trap_state_e;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for an asynchronous level input.
// Depth is STAGES (>= 2); the chain holds while en is low.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ff_q <= '0;
    end else if (en) begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap-return controller and trap CSRs.
// Define IRQ_VECTORED_EN to enable vectored mtvec mode.
module irq_trap_ctrl
  import riscv_trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   enable_design,
  input  logic                   irq_ext_i,
  input  logic                   irq_timer_i,
  input  logic                   irq_sw_i,
  input  logic                   commit_valid_i,
  input  logic [`size_X_LEN-1:0] commit_next_pc_i,
  input  logic                   redirect_pending_i,
  input  logic                   mret_inst_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [`size_X_LEN-1:0] csr_wdata_i,
  output logic [`size_X_LEN-1:0] csr_rdata_o,
  output logic                   irq_prep_o,
  output logic [`size_X_LEN-1:0] interrupt_vector_o,
  output logic [`size_X_LEN-1:0] mepc_o,
  output logic [`size_X_LEN-1:0] mcause_o,
  output logic                   mie_global_o
);

  trap_state_e state_q, state_d;

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic        meip;
  logic [31:0] mip;
  logic        p_mei, p_msi, p_mti;
  logic        take;
  logic [3:0]  cause_code;
  logic [31:0] base;
  logic        wr_mstatus, wr_mie, wr_mtvec;
  logic        wr_mepc, wr_mcause;
  logic        unused_pc_lsb;

  irq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ext_sync (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .en      (enable_design),
    .d       (irq_ext_i),
    .q       (meip)
  );

  // mtvec legalization: mode field only exists in vectored builds
  function automatic logic [31:0] mtvec_legal(input logic [31:0] v);
`ifdef IRQ_VECTORED_EN
    return {v[31:2], 1'b0, (v[1:0] == 2'b01)};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  assign mip = {20'b0, meip, 3'b0, irq_timer_i,
                3'b0, irq_sw_i, 3'b0};

  assign p_mei = mip[11] & mie_q[11];
  assign p_msi = mip[3]  & mie_q[3];
  assign p_mti = mip[7]  & mie_q[7];

  always_comb begin
    cause_code = CAUSE_MTI;
    if (p_mei)      cause_code = CAUSE_MEI;
    else if (p_msi) cause_code = CAUSE_MSI;
  end

  assign take = mstatus_mie_q
              & (p_mei | p_msi | p_mti)
              & commit_valid_i
              & ~redirect_pending_i
              & ~mret_inst_i
              & (state_q != FIRE);

  assign wr_mstatus = csr_we_i & (csr_addr_i == CSR_MSTATUS);
  assign wr_mie     = csr_we_i & (csr_addr_i == CSR_MIE);
  assign wr_mtvec   = csr_we_i & (csr_addr_i == CSR_MTVEC);
  assign wr_mepc    = csr_we_i & (csr_addr_i == CSR_MEPC);
  assign wr_mcause  = csr_we_i & (csr_addr_i == CSR_MCAUSE);

  assign unused_pc_lsb = ^commit_next_pc_i[1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = FIRE;
      FIRE:    state_d = HANDLER;
      HANDLER: begin
        if (take)             state_d = FIRE;
        else if (mret_inst_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= mtvec_legal(RESET_MTVEC);
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else if (enable_design) begin
      state_q <= state_d;
      // trap capture outranks software writes to the same CSRs
      if (take) begin
        mepc_q         <= {commit_next_pc_i[31:2], 2'b00};
        mcause_q       <= {1'b1, 27'b0, cause_code};
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else begin
        if (mret_inst_i) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE];
          mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
        end
        if (wr_mepc)   mepc_q   <= {csr_wdata_i[31:2], 2'b00};
        if (wr_mcause) mcause_q <= csr_wdata_i;
      end
      if (wr_mie)   mie_q   <= csr_wdata_i & MIE_MASK;
      if (wr_mtvec) mtvec_q <= mtvec_legal(csr_wdata_i);
    end
  end

  assign base = {mtvec_q[31:2], 2'b00};

`ifdef IRQ_VECTORED_EN
  assign interrupt_vector_o = (mtvec_q[1:0] == 2'b01)
                            ? base + {26'b0, mcause_q[3:0], 2'b00}
                            : base;
`else
  assign interrupt_vector_o = base;
`endif

  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE]  = mstatus_mie_q;
        csr_rdata_o[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_MIE:    csr_rdata_o = mie_q;
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MIP:    csr_rdata_o = mip;
      default:    csr_rdata_o = '0;
    endcase
  end

  assign irq_prep_o   = enable_design & (state_q == FIRE);
  assign mepc_o       = mepc_q;
  assign mcause_o     = mcause_q;
  assign mie_global_o = mstatus_mie_q;

endmodule
